// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP send-path DMA engine.
package sfp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } sfp_state_e;

    localparam int unsigned STAT_BUSY_BIT = 31;
    localparam int unsigned STAT_ERR_BIT  = 30;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned AXI_4K_BYTES = 4096;

endpackage

// File: rtl/sfp_send_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module sfp_send_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Upstream credit accounting must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (count_q == (AW+1)'(DEPTH))));

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sfp_send_dma.sv
// Send-path DMA: AXI4 burst reads from host memory forwarded as one AXI-Stream frame.
// Optional SFP_SEND_DMA_BYTESWAP_EN byte-reverses each beat on its way into the FIFO.
module sfp_send_dma
    import sfp_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST  = 16,
    parameter int unsigned C_FIFO_DEPTH = 64
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        send_start,
    input  logic [31:0]                 send_length,
    input  logic [31:0]                 send_inbuf_ptr,
    output logic                        send_init,
    output logic [31:0]                 send_buff_statue,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [C_ADDR_WIDTH-1:0]     m_araddr,
    output logic [7:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [C_DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    output logic                        tx_tvalid,
    input  logic                        tx_tready,
    output logic [C_DATA_WIDTH-1:0]     tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0]   tx_tkeep,
    output logic                        tx_tlast
);

    localparam int unsigned B  = C_DATA_WIDTH / 8;
    localparam int unsigned LB = $clog2(B);
    localparam int unsigned OW = $clog2(C_FIFO_DEPTH) + 1;

    sfp_state_e              state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [32:0]             rem_q, rem_d;
    logic [32:0]             nbeats_q, nbeats_d;
    logic [32:0]             txcnt_q, txcnt_d;
    logic [LB-1:0]           tail_q, tail_d;
    logic [OW-1:0]           outst_q, outst_d;
    logic                    err_q, err_d;

    logic [32:0]             len_beats;
    logic [12:0]             bytes_4k;
    logic [12:0]             beats_4k;
    logic [32:0]             burst_w;
    logic                    credit_ok;
    logic                    ar_hs, r_hs, tx_hs;
    logic [OW-1:0]           occ;
    logic                    fifo_empty;
    logic [C_DATA_WIDTH-1:0] wr_data;
    logic [B-1:0]            keep_last;
    logic                    unused_sig;

    assign len_beats = ({1'b0, send_length} + 33'(B - 1)) >> LB;

    // Burst = min(remaining, max burst, beats left before the next 4 KB page).
    assign bytes_4k = 13'(AXI_4K_BYTES) - 13'(addr_q[11:0]);
    assign beats_4k = bytes_4k >> LB;

    always_comb begin
        burst_w = 33'(C_MAX_BURST);
        if (rem_q < burst_w) begin
            burst_w = rem_q;
        end
        if (33'(beats_4k) < burst_w) begin
            burst_w = 33'(beats_4k);
        end
    end

    assign credit_ok = (32'(occ) + 32'(outst_q) + 32'(burst_w[8:0])) <= 32'(C_FIFO_DEPTH);

    assign m_arvalid = (state_q == ST_ISSUE) && credit_ok;
    assign m_araddr  = addr_q;
    assign m_arlen   = 8'(burst_w - 33'd1);
    assign m_arsize  = 3'(LB);
    assign m_arburst = AXI_BURST_INCR;
    assign m_rready  = (state_q != ST_IDLE);

    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid && m_rready;
    assign tx_hs = tx_tvalid && tx_tready;

`ifdef SFP_SEND_DMA_BYTESWAP_EN
    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < B; i++) begin
            wr_data[8*i +: 8] = m_rdata[8*(B-1-i) +: 8];
        end
    end
`else
    assign wr_data = m_rdata;
`endif

    sfp_send_fifo #(
        .DEPTH (C_FIFO_DEPTH),
        .WIDTH (C_DATA_WIDTH)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (r_hs),
        .din_i   (wr_data),
        .pop_i   (tx_hs),
        .dout_o  (tx_tdata),
        .empty_o (fifo_empty),
        .count_o (occ)
    );

    always_comb begin
        keep_last = '0;
        for (int unsigned i = 0; i < B; i++) begin
            keep_last[i] = (tail_q == '0) || (i < 32'(tail_q));
        end
    end

    assign tx_tvalid = !fifo_empty;
    assign tx_tlast  = tx_tvalid && (txcnt_q == nbeats_q - 33'd1);
    assign tx_tkeep  = !tx_tvalid ? '0 : (tx_tlast ? keep_last : '1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        nbeats_d = nbeats_q;
        txcnt_d  = txcnt_q;
        tail_d   = tail_q;
        err_d    = err_q;
        outst_d  = outst_q + (ar_hs ? OW'(burst_w) : '0) - (r_hs ? OW'(1) : '0);
        if (tx_hs) begin
            txcnt_d = txcnt_q + 33'd1;
        end
        if (r_hs && (m_rresp != AXI_RESP_OKAY)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (send_start) begin
                    addr_d   = C_ADDR_WIDTH'({send_inbuf_ptr[31:LB], {LB{1'b0}}});
                    rem_d    = len_beats;
                    nbeats_d = len_beats;
                    txcnt_d  = '0;
                    tail_d   = send_length[LB-1:0];
                    err_d    = 1'b0;
                    outst_d  = '0;
                    state_d  = (send_length == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ar_hs) begin
                    addr_d = addr_q + C_ADDR_WIDTH'({burst_w[8:0], {LB{1'b0}}});
                    rem_d  = rem_q - burst_w;
                    if (rem_q == burst_w) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tx_hs && tx_tlast) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            nbeats_q <= '0;
            txcnt_q  <= '0;
            tail_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            nbeats_q <= nbeats_d;
            txcnt_q  <= txcnt_d;
            tail_q   <= tail_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

    assign send_init = (state_q == ST_DONE);

    always_comb begin
        send_buff_statue                = {16'd0, 16'(occ)};
        send_buff_statue[STAT_BUSY_BIT] = (state_q != ST_IDLE);
        send_buff_statue[STAT_ERR_BIT]  = err_q;
    end

    assign unused_sig = ^{m_rlast, burst_w[32:9], send_inbuf_ptr[LB-1:0]};

endmodule

// File: tb/tb_sfp_send_dma.sv
// Scoreboard bench for sfp_send_dma: memory-model AXI slave, expected AR/TX queues, monitor.
module tb_sfp_send_dma;

    logic        aclk = 1'b0;
    logic        areset;
    logic        send_start;
    logic [31:0] send_length;
    logic [31:0] send_inbuf_ptr;
    logic        send_init;
    logic [31:0] send_buff_statue;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast;

    sfp_send_dma #(
        .C_ADDR_WIDTH (64),
        .C_DATA_WIDTH (64),
        .C_MAX_BURST  (16),
        .C_FIFO_DEPTH (64)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .send_start       (send_start),
        .send_length      (send_length),
        .send_inbuf_ptr   (send_inbuf_ptr),
        .send_init        (send_init),
        .send_buff_statue (send_buff_statue),
        .m_arvalid        (m_arvalid),
        .m_arready        (m_arready),
        .m_araddr         (m_araddr),
        .m_arlen          (m_arlen),
        .m_arsize         (m_arsize),
        .m_arburst        (m_arburst),
        .m_rvalid         (m_rvalid),
        .m_rready         (m_rready),
        .m_rdata          (m_rdata),
        .m_rresp          (m_rresp),
        .m_rlast          (m_rlast),
        .tx_tvalid        (tx_tvalid),
        .tx_tready        (tx_tready),
        .tx_tdata         (tx_tdata),
        .tx_tkeep         (tx_tkeep),
        .tx_tlast         (tx_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    beat_t exp_tx[$];
    ar_t   exp_ar[$];
    ar_t   slv_q[$];

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int ar_beats = 0;
    int rcnt = 0;
    int slv_beat = 0;
    int err_beat = -1;
    logic bp = 1'b0;
    logic init_pending = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {~a[31:0] ^ 32'h5A00_C300, a[31:0] + 32'h0102_0304};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input logic [31:0] ptr, input logic [31:0] len);
        @(posedge aclk);
        #1;
        send_start     = 1'b1;
        send_inbuf_ptr = ptr;
        send_length    = len;
        @(posedge aclk);
        #1;
        send_start = 1'b0;
    endtask

    task automatic expect_frame(input logic [31:0] ptr, input int len);
        logic [63:0] a0;
        int          n;
        int          t;
        beat_t       b;
        a0 = {32'd0, ptr & 32'hFFFF_FFF8};
        n  = (len + 7) / 8;
        t  = len % 8;
        for (int i = 0; i < n; i++) begin
            b.data = mem_word(a0 + 64'(i) * 64'd8);
            b.keep = (i == n - 1 && t != 0) ? (8'hFF >> (8 - t)) : 8'hFF;
            b.last = (i == n - 1);
            exp_tx.push_back(b);
        end
    endtask

    task automatic expect_ar(input logic [63:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr = addr;
        a.len  = len;
        exp_ar.push_back(a);
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (exp_tx.size() == 0 && exp_ar.size() == 0 && !send_buff_statue[31] && !init_pending)
                return;
        end
        check({name, "_timeout"}, 1, 0);
    endtask

    // AXI4 read slave backed by the mem_word() memory model
    initial begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                slv_q.delete();
                slv_beat = 0;
            end else begin
                if (m_arvalid && m_arready) begin
                    ar_t a;
                    a.addr = m_araddr;
                    a.len  = m_arlen;
                    slv_q.push_back(a);
                end
                if (m_rvalid && m_rready) begin
                    rcnt++;
                    if (slv_beat == int'(slv_q[0].len)) begin
                        void'(slv_q.pop_front());
                        slv_beat = 0;
                    end else begin
                        slv_beat++;
                    end
                end
            end
            @(posedge aclk);
            #1;
            m_arready = (cyc % 3 != 0);
            if (slv_q.size() > 0 && (cyc % 5 != 2)) begin
                m_rvalid = 1'b1;
                m_rdata  = mem_word(slv_q[0].addr + 64'(slv_beat) * 64'd8);
                m_rlast  = (slv_beat == int'(slv_q[0].len));
                m_rresp  = (rcnt == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                m_rresp  = 2'b00;
            end
        end
    end

    initial begin
        tx_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            tx_tready = bp ? 1'b0 : (cyc % 4 != 1);
        end
    end

    // Monitor: pops expected AR/TX entries on handshakes and checks handshake stability
    initial begin
        logic         ar_hold;
        logic         tx_hold;
        logic [127:0] ar_held;
        logic [127:0] tx_held;
        ar_hold = 1'b0;
        tx_hold = 1'b0;
        ar_held = '0;
        tx_held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                exp_tx.delete();
                exp_ar.delete();
                init_pending = 1'b0;
                ar_hold = 1'b0;
                tx_hold = 1'b0;
            end else begin
                if (send_init || init_pending)
                    check("send_init", 128'(send_init), 128'(init_pending));
                init_pending = 1'b0;
                if (ar_hold)
                    check("ar_hold", {m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst}, ar_held);
                if (tx_hold)
                    check("tx_hold", {tx_tvalid, tx_tdata, tx_tkeep, tx_tlast}, tx_held);
                ar_hold = m_arvalid && !m_arready;
                ar_held = {m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst};
                tx_hold = tx_tvalid && !tx_tready;
                tx_held = {tx_tvalid, tx_tdata, tx_tkeep, tx_tlast};
                if (m_arvalid && m_arready) begin
                    ar_beats += int'(m_arlen) + 1;
                    if (exp_ar.size() == 0) begin
                        check("ar_extra", {m_araddr, m_arlen}, 0);
                    end else begin
                        ar_t e;
                        e = exp_ar.pop_front();
                        check("ar_addr_len", {m_araddr, m_arlen, m_arsize, m_arburst},
                              {e.addr, e.len, 3'd3, 2'b01});
                    end
                end
                if (tx_tvalid && tx_tready) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_extra", {tx_tdata, tx_tkeep, tx_tlast}, 0);
                    end else begin
                        beat_t e;
                        e = exp_tx.pop_front();
                        check("tx_beat", {tx_tdata, tx_tkeep, tx_tlast}, {e.data, e.keep, e.last});
                    end
                    if (tx_tlast)
                        init_pending = 1'b1;
                end
                if (send_start && !send_buff_statue[31] && send_length == 0)
                    init_pending = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        areset         = 1'b1;
        send_start     = 1'b0;
        send_length    = '0;
        send_inbuf_ptr = '0;
        repeat (3) tick();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_outputs", {m_arvalid, m_rready, tx_tvalid, tx_tlast, tx_tkeep, send_init}, 0);
        check("rst_status", send_buff_statue, 0);

        // single beat: len 5 at 0x1000
        expect_ar(64'h1000, 8'd0);
        expect_frame(32'h1000, 5);
        start(32'h1000, 5);
        @(negedge aclk);
        check("first_arvalid", m_arvalid, 1);
        wait_idle(200, "single");

        // 4 KB boundary split, with a start pulse while busy
        expect_ar(64'h0FC0, 8'd7);
        expect_ar(64'h1000, 8'd15);
        expect_ar(64'h1080, 8'd7);
        expect_frame(32'h0FC0, 256);
        ar_beats = 0;
        start(32'h0FC0, 256);
        for (int i = 0; i < 100 && ar_beats == 0; i++) tick();
        start(32'h9000, 8);
        wait_idle(1000, "split");

        // zero length
        start(32'h5000, 0);
        wait_idle(20, "zero");
        repeat (3) @(negedge aclk);
        check("zero_not_busy", send_buff_statue[31], 0);

        // backpressure: fill FIFO credits then release
        bp = 1'b1;
        for (int i = 0; i < 32; i++) expect_ar(64'(i) * 64'd128, 8'd15);
        expect_frame(32'h0, 4096);
        ar_beats = 0;
        start(32'h0, 4096);
        repeat (500) tick();
        @(negedge aclk);
        check("bp_occupancy", send_buff_statue[15:0], 64);
        check("bp_ar_beats", ar_beats, 64);
        bp = 1'b0;
        wait_idle(5000, "bp");

        // error response on beat 3
        err_beat = rcnt + 3;
        expect_ar(64'h3000, 8'd7);
        expect_frame(32'h3000, 64);
        start(32'h3000, 64);
        wait_idle(500, "err");
        check("err_sticky", send_buff_statue[30], 1);
        err_beat = -1;
        expect_ar(64'h3100, 8'd0);
        expect_frame(32'h3100, 8);
        start(32'h3100, 8);
        @(negedge aclk);
        check("err_cleared", send_buff_statue[30], 0);
        wait_idle(200, "err_clr");

        // reset mid-frame
        bp = 1'b1;
        for (int i = 0; i < 8; i++) expect_ar(64'h2000 + 64'(i) * 64'd128, 8'd15);
        start(32'h2000, 1024);
        repeat (20) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        bp = 1'b0;
        @(negedge aclk);
        check("midrst_outputs", {m_arvalid, m_rready, tx_tvalid, tx_tlast, tx_tkeep, send_init}, 0);
        check("midrst_status", send_buff_statue, 0);

        // post-reset frame must not see stale FIFO contents
        expect_ar(64'h0040, 8'd0);
        expect_frame(32'h0043, 3);
        start(32'h0043, 3);
        wait_idle(200, "post_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
